// File: rtl/hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller: controller states,
// decode-stage jump kinds and the hard-wired zero register.
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DSTALL = 2'b01,
        ST_MWAIT  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        JMP_NONE  = 2'b00,
        JMP_J     = 2'b01,
        JMP_JR    = 2'b10,
        JMP_RSVD  = 2'b11
    } jump_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_controller_detect.sv
// Combinational hazard and redirect detection from the decode sources
// against the EX and MEM destinations.
module hazard_detect
    import hazard_controller_pkg::*;
(
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic       use_rs1_d,
    input  logic       use_rs2_d,
    input  logic       branch_d,
    input  logic [1:0] jump_d,
    input  logic       taken_d,
    input  logic [4:0] rd_e,
    input  logic       reg_write_e,
    input  logic       mem_read_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    output logic       hazard,
    output logic       redirect
);

    logic hit_e;
    logic hit_m;
    logic load_use;
    logic branch_hazard;
    logic decode_compare;
    logic is_jr;
    logic is_j;

    // The zero register is never a real producer, so any match on it is ignored.
    assign hit_e = (rd_e != REG_ZERO) &&
                   ((use_rs1_d && (rs1_d == rd_e)) || (use_rs2_d && (rs2_d == rd_e)));
    assign hit_m = (rd_m != REG_ZERO) &&
                   ((use_rs1_d && (rs1_d == rd_m)) || (use_rs2_d && (rs2_d == rd_m)));

    assign is_jr          = (jump_t'(jump_d) == JMP_JR);
    assign is_j           = (jump_t'(jump_d) == JMP_J);
    assign decode_compare = branch_d || is_jr;

    assign load_use      = mem_read_e && hit_e;
    assign branch_hazard = decode_compare && ((reg_write_e && hit_e) || (reg_write_m && hit_m));

    assign hazard   = load_use || branch_hazard;
    assign redirect = !hazard && ((branch_d && taken_d) || is_j || is_jr);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: priority mux for stall/flush/bubble
// controls, the RUN/DSTALL/MWAIT state register and saturating counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic             branch_d,
    input  logic [1:0]       jump_d,
    input  logic             taken_d,
    input  logic [4:0]       rd_e,
    input  logic             reg_write_e,
    input  logic             mem_read_e,
    input  logic [4:0]       rd_m,
    input  logic             reg_write_m,
    input  logic             mem_read_m,
    input  logic             dmem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    state_t state_q;
    state_t state_n;
    logic   hazard;
    logic   redirect;
    logic   unused_inputs;

    // A MEM-stage load is already covered by reg_write_m for decode compares.
    assign unused_inputs = mem_read_m;

    hazard_detect u_detect (
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .use_rs1_d   (use_rs1_d),
        .use_rs2_d   (use_rs2_d),
        .branch_d    (branch_d),
        .jump_d      (jump_d),
        .taken_d     (taken_d),
        .rd_e        (rd_e),
        .reg_write_e (reg_write_e),
        .mem_read_e  (mem_read_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .hazard      (hazard),
        .redirect    (redirect)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_n;
        end
    end

    // Priority: reset > memory wait > decode hazard > redirect.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        state_n      = ST_RUN;

        if (reset) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (dmem_busy) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            state_n      = ST_MWAIT;
        end else if (hazard) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_flush   = 1'b1;
            state_n      = ST_DSTALL;
        end else if (redirect) begin
            ifid_flush   = 1'b1;
        end
    end

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (ifid_flush && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench: directed scenarios from the pipeline's point of view
// plus randomized cycles against a rule-level reference model.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_d, rs2_d;
    logic        use_rs1_d, use_rs2_d, branch_d, taken_d;
    logic [1:0]  jump_d;
    logic [4:0]  rd_e, rd_m;
    logic        reg_write_e, mem_read_e, reg_write_m, mem_read_m, dmem_busy;

    logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble;
    logic [1:0]  state;
    logic [15:0] stall_cycles, flush_count;

    logic        pc_en4, ifid_en4, idex_en4, exmem_en4, ifid_flush4, idex_flush4, memwb_bubble4;
    logic [1:0]  state4;
    logic [3:0]  stall_cycles4, flush_count4;

    logic [6:0]  ctrl;

    int checks = 0;
    int errors = 0;

    // Expected values for the random test, maintained at the rule level.
    int m_state, m_stall, m_flush, m_stall4, m_flush4;

    // Packed view: {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble}
    localparam logic [6:0] C_NORMAL   = 7'b1111000;
    localparam logic [6:0] C_HAZARD   = 7'b0011010;
    localparam logic [6:0] C_REDIRECT = 7'b1111100;
    localparam logic [6:0] C_BUSY     = 7'b0000001;
    localparam logic [6:0] C_RESET    = 7'b0000111;

    assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble};

    always #5 clk = ~clk;

    hazard_controller #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .branch_d(branch_d), .jump_d(jump_d), .taken_d(taken_d),
        .rd_e(rd_e), .reg_write_e(reg_write_e), .mem_read_e(mem_read_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_read_m(mem_read_m),
        .dmem_busy(dmem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
        .state(state), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    hazard_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .branch_d(branch_d), .jump_d(jump_d), .taken_d(taken_d),
        .rd_e(rd_e), .reg_write_e(reg_write_e), .mem_read_e(mem_read_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_read_m(mem_read_m),
        .dmem_busy(dmem_busy),
        .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_en(idex_en4), .exmem_en(exmem_en4),
        .ifid_flush(ifid_flush4), .idex_flush(idex_flush4), .memwb_bubble(memwb_bubble4),
        .state(state4), .stall_cycles(stall_cycles4), .flush_count(flush_count4)
    );

    // A source is "in danger" from a producer if it is read, nonzero and equal.
    function automatic bit reads_reg(input logic [4:0] r);
        bit hit;
        logic [4:0] srcs [2];
        bit         used [2];
        srcs[0] = rs1_d; used[0] = use_rs1_d;
        srcs[1] = rs2_d; used[1] = use_rs2_d;
        hit = 0;
        for (int i = 0; i < 2; i++) begin
            if (used[i] && srcs[i] == r && r != 5'd0) hit = 1;
        end
        return hit;
    endfunction

    function automatic bit model_hazard();
        bit compares_in_decode;
        compares_in_decode = branch_d || (jump_d == 2'd2);
        if (mem_read_e && reads_reg(rd_e)) return 1;
        if (compares_in_decode && reg_write_e && reads_reg(rd_e)) return 1;
        if (compares_in_decode && reg_write_m && reads_reg(rd_m)) return 1;
        return 0;
    endfunction

    function automatic logic [6:0] model_ctrl();
        bit wants_redirect;
        wants_redirect = (branch_d && taken_d) || jump_d == 2'd1 || jump_d == 2'd2;
        if (reset)          return C_RESET;
        if (dmem_busy)      return C_BUSY;
        if (model_hazard()) return C_HAZARD;
        if (wants_redirect) return C_REDIRECT;
        return C_NORMAL;
    endfunction

    task automatic clear_inputs();
        reset = 0; rs1_d = 0; rs2_d = 0; use_rs1_d = 0; use_rs2_d = 0;
        branch_d = 0; jump_d = 0; taken_d = 0;
        rd_e = 0; reg_write_e = 0; mem_read_e = 0;
        rd_m = 0; reg_write_m = 0; mem_read_m = 0; dmem_busy = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        next_cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1; dmem_busy = 1; mem_read_e = 1; rd_e = 5; rs1_d = 5; use_rs1_d = 1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_RESET) begin
            errors++; $display("[TB] FAIL reset_ctrl got %b want %b", ctrl, C_RESET);
        end
        next_cycle();
        checks++;
        if (state !== 2'd0 || stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_regs got st=%0d stall=%0d flush=%0d want 0 0 0",
                     state, stall_cycles, flush_count);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        // EX: lw $5; decode: add reads $5 and $7
        rd_e = 5; reg_write_e = 1; mem_read_e = 1;
        rs1_d = 5; rs2_d = 7; use_rs1_d = 1; use_rs2_d = 1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_HAZARD) begin
            errors++; $display("[TB] FAIL load_use_ctrl got %b want %b", ctrl, C_HAZARD);
        end
        next_cycle();
        checks++;
        if (state !== 2'd1 || stall_cycles !== 16'd1) begin
            errors++; $display("[TB] FAIL load_use_stall got st=%0d stall=%0d want 1 1", state, stall_cycles);
        end
        // Bubble now in EX, load in MEM
        rd_e = 0; reg_write_e = 0; mem_read_e = 0;
        rd_m = 5; reg_write_m = 1; mem_read_m = 1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_NORMAL) begin
            errors++; $display("[TB] FAIL load_use_release got %b want %b", ctrl, C_NORMAL);
        end
        next_cycle();
        checks++;
        if (state !== 2'd0 || stall_cycles !== 16'd1) begin
            errors++; $display("[TB] FAIL load_use_after got st=%0d stall=%0d want 0 1", state, stall_cycles);
        end
    endtask

    task automatic test_branch_alu();
        do_reset();
        // EX: add $3; decode: beq $3,$0 taken
        rd_e = 3; reg_write_e = 1;
        rs1_d = 3; rs2_d = 0; use_rs1_d = 1; use_rs2_d = 1; branch_d = 1; taken_d = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (ctrl !== C_HAZARD) begin
                errors++; $display("[TB] FAIL branch_alu_stall%0d got %b want %b", c, ctrl, C_HAZARD);
            end
            next_cycle();
            // Producer advances into MEM behind the bubble
            rd_e = 0; reg_write_e = 0;
            rd_m = (c == 0) ? 5'd3 : 5'd0; reg_write_m = (c == 0);
        end
        @(negedge clk);
        checks++;
        if (ctrl !== C_REDIRECT) begin
            errors++; $display("[TB] FAIL branch_alu_redirect got %b want %b", ctrl, C_REDIRECT);
        end
        next_cycle();
        checks++;
        if (stall_cycles !== 16'd2 || flush_count !== 16'd1 || state !== 2'd0) begin
            errors++;
            $display("[TB] FAIL branch_alu_counts got stall=%0d flush=%0d st=%0d want 2 1 0",
                     stall_cycles, flush_count, state);
        end
    endtask

    task automatic test_reg0_jr();
        do_reset();
        rd_e = 0; reg_write_e = 1; rs1_d = 0; rs2_d = 0; use_rs1_d = 1; use_rs2_d = 1; branch_d = 1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_NORMAL) begin
            errors++; $display("[TB] FAIL reg0_no_stall got %b want %b", ctrl, C_NORMAL);
        end
        next_cycle();
        clear_inputs();
        // jr $31 while MEM holds the writer of $31
        jump_d = 2'd2; rs1_d = 31; use_rs1_d = 1; rd_m = 31; reg_write_m = 1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_HAZARD) begin
            errors++; $display("[TB] FAIL jr_stall got %b want %b", ctrl, C_HAZARD);
        end
        next_cycle();
        rd_m = 0; reg_write_m = 0;
        @(negedge clk);
        checks++;
        if (ctrl !== C_REDIRECT) begin
            errors++; $display("[TB] FAIL jr_redirect got %b want %b", ctrl, C_REDIRECT);
        end
        next_cycle();
        checks++;
        if (stall_cycles !== 16'd1 || flush_count !== 16'd1) begin
            errors++; $display("[TB] FAIL jr_counts got stall=%0d flush=%0d want 1 1", stall_cycles, flush_count);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        rd_e = 5; reg_write_e = 1; mem_read_e = 1; rs1_d = 5; use_rs1_d = 1; dmem_busy = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ctrl !== C_BUSY) begin
                errors++; $display("[TB] FAIL mwait_ctrl%0d got %b want %b", c, ctrl, C_BUSY);
            end
            next_cycle();
            checks++;
            if (state !== 2'd2) begin
                errors++; $display("[TB] FAIL mwait_state%0d got %0d want 2", c, state);
            end
        end
        dmem_busy = 0;
        @(negedge clk);
        checks++;
        if (ctrl !== C_HAZARD) begin
            errors++; $display("[TB] FAIL mwait_rehazard got %b want %b", ctrl, C_HAZARD);
        end
        next_cycle();
        checks++;
        if (state !== 2'd1) begin
            errors++; $display("[TB] FAIL mwait_dstall got %0d want 1", state);
        end
        rd_e = 0; reg_write_e = 0; mem_read_e = 0; rd_m = 5; reg_write_m = 1; mem_read_m = 1;
        next_cycle();
        checks++;
        if (state !== 2'd0 || stall_cycles !== 16'd4) begin
            errors++; $display("[TB] FAIL mwait_final got st=%0d stall=%0d want 0 4", state, stall_cycles);
        end
    endtask

    task automatic test_redirect_suppress();
        do_reset();
        rd_e = 9; reg_write_e = 1; rs2_d = 9; use_rs2_d = 1; branch_d = 1; taken_d = 1;
        @(negedge clk);
        checks++;
        if (ifid_flush !== 1'b0 || pc_en !== 1'b0) begin
            errors++; $display("[TB] FAIL suppress got ifid_flush=%b pc_en=%b want 0 0", ifid_flush, pc_en);
        end
        next_cycle();
        checks++;
        if (flush_count !== 16'd0) begin
            errors++; $display("[TB] FAIL suppress_count got %0d want 0", flush_count);
        end
    endtask

    task automatic test_reset_mid_mwait();
        do_reset();
        dmem_busy = 1;
        next_cycle();
        next_cycle();
        reset = 1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_RESET) begin
            errors++; $display("[TB] FAIL mwait_reset_ctrl got %b want %b", ctrl, C_RESET);
        end
        next_cycle();
        checks++;
        if (state !== 2'd0 || stall_cycles !== 16'd0) begin
            errors++; $display("[TB] FAIL mwait_reset got st=%0d stall=%0d want 0 0", state, stall_cycles);
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        dmem_busy = 1;
        repeat (20) next_cycle();
        dmem_busy = 0; jump_d = 2'd1;
        repeat (18) next_cycle();
        checks++;
        if (stall_cycles4 !== 4'd15 || flush_count4 !== 4'd15) begin
            errors++; $display("[TB] FAIL sat4 got stall=%0d flush=%0d want 15 15", stall_cycles4, flush_count4);
        end
        checks++;
        if (stall_cycles !== 16'd20 || flush_count !== 16'd18) begin
            errors++; $display("[TB] FAIL sat16 got stall=%0d flush=%0d want 20 18", stall_cycles, flush_count);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [6:0] want;
        bit         haz;
        do_reset();
        m_state = 0; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 49) == 0);
            rs1_d       = 5'($urandom_range(0, 3));
            rs2_d       = 5'($urandom_range(0, 3));
            use_rs1_d   = 1'($urandom);
            use_rs2_d   = 1'($urandom);
            branch_d    = 1'($urandom);
            jump_d      = 2'($urandom);
            taken_d     = 1'($urandom);
            rd_e        = 5'($urandom_range(0, 3));
            reg_write_e = 1'($urandom);
            mem_read_e  = ($urandom_range(0, 3) == 0);
            rd_m        = 5'($urandom_range(0, 3));
            reg_write_m = 1'($urandom);
            mem_read_m  = 1'($urandom);
            dmem_busy   = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            want = model_ctrl();
            haz  = model_hazard();
            checks++;
            if (ctrl !== want) begin
                errors++; $display("[TB] FAIL rand_ctrl cycle %0d got %b want %b", n, ctrl, want);
            end
            if (reset) begin
                m_state = 0; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
            end else begin
                m_state = dmem_busy ? 2 : (haz ? 1 : 0);
                if (!want[6]) begin
                    m_stall  = (m_stall  < 65535) ? m_stall  + 1 : m_stall;
                    m_stall4 = (m_stall4 < 15)    ? m_stall4 + 1 : m_stall4;
                end
                if (want[2]) begin
                    m_flush  = (m_flush  < 65535) ? m_flush  + 1 : m_flush;
                    m_flush4 = (m_flush4 < 15)    ? m_flush4 + 1 : m_flush4;
                end
            end
            next_cycle();
            checks++;
            if (int'(state) != m_state || int'(stall_cycles) != m_stall || int'(flush_count) != m_flush ||
                int'(stall_cycles4) != m_stall4 || int'(flush_count4) != m_flush4) begin
                errors++;
                $display("[TB] FAIL rand_regs cycle %0d got st=%0d s=%0d f=%0d s4=%0d f4=%0d want %0d %0d %0d %0d %0d",
                         n, state, stall_cycles, flush_count, stall_cycles4, flush_count4,
                         m_state, m_stall, m_flush, m_stall4, m_flush4);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        #1;
        test_reset();
        test_load_use();
        test_branch_alu();
        test_reg0_jr();
        test_mem_wait();
        test_redirect_suppress();
        test_reset_mid_mwait();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
